// File: rtl/alu_seq_ctrl_pkg.sv
// definitions: ALU opcode enumeration plus the sequencer command and state types.
package definitions;

    typedef enum logic [2:0] {
        ADD   = 3'd0,
        SUB   = 3'd1,
        LSH   = 3'd2,
        RSH   = 3'd3,
        ANDOP = 3'd4,
        OROP  = 3'd5,
        XOROP = 3'd6,
        PASSA = 3'd7
    } alu_op_t;

    typedef enum logic [1:0] {
        CMD_SUBZ = 2'b00,
        CMD_MUL  = 2'b01,
        CMD_POP  = 2'b10,
        CMD_RSV  = 2'b11
    } seq_cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        ADD_PH,
        SHF_PH,
        DONE
    } seq_state_t;

endpackage

// File: rtl/alu_seq_ctrl_alu.sv
// ALU: single-cycle W-bit ALU; shifts move InputA by InputB bit positions, zero-filled.
module ALU
    import definitions::*;
#(
    parameter int W   = 8,
    parameter int Ops = 3
) (
    input  logic [Ops-1:0] OP,
    input  logic [W-1:0]   InputA,
    input  logic [W-1:0]   InputB,
    input  logic           SC_in,
    output logic [W-1:0]   Result,
    output logic           SC_out,
    output logic           Zero,
    output logic           Parity,
    output logic           Odd
);

    logic [W:0] sum;

    always_comb begin
        sum    = '0;
        Result = '0;
        SC_out = 1'b0;
        case (OP)
            Ops'(ADD): begin
                sum    = {1'b0, InputA} + {1'b0, InputB} + {{W{1'b0}}, SC_in};
                Result = sum[W-1:0];
                SC_out = sum[W];
            end
            // SC_out carries the borrow for SUB
            Ops'(SUB): begin
                sum    = {1'b0, InputA} - {1'b0, InputB};
                Result = sum[W-1:0];
                SC_out = sum[W];
            end
            Ops'(LSH):   Result = InputA << InputB;
            Ops'(RSH):   Result = InputA >> InputB;
            Ops'(ANDOP): Result = InputA & InputB;
            Ops'(OROP):  Result = InputA | InputB;
            Ops'(XOROP): Result = InputA ^ InputB;
            Ops'(PASSA): Result = InputA;
            default:     Result = '0;
        endcase
    end

    assign Zero   = ~|Result;
    assign Parity = ^Result;
    assign Odd    = Result[0];

endmodule

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: multi-cycle MUL/POP/SUBZ sequencer driving a private ALU one primitive op per cycle.
// Build option ALU_SEQ_EARLY_EXIT_EN: finish MUL/POP as soon as the remaining operand is zero.
module alu_seq_ctrl
    import definitions::*;
#(
    parameter int W   = 8,
    parameter int Ops = 3
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [1:0]   req_cmd,
    input  logic [W-1:0] req_a,
    input  logic [W-1:0] req_b,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_data,
    output logic         rsp_zero,
    output logic         busy
);

    // state  | meaning
    // IDLE   | waiting for a command, req_ready high
    // ADD_PH | ALU ADD/SUB into acc
    // SHF_PH | ALU shift of x by one, local y shift, iter++
    // DONE   | result held on rsp_data until rsp_ready

    localparam int            IW        = $clog2(W + 1);
    localparam logic [IW-1:0] LAST_ITER = IW'(W - 1);

    seq_state_t     state, state_nxt;
    seq_cmd_t       cmd;
    logic [W-1:0]   acc, x, y;
    logic [IW-1:0]  iter;
    logic [Ops-1:0] alu_op;
    logic [W-1:0]   alu_a, alu_b, alu_res;
    logic           alu_sc_unused, alu_zero_unused, alu_parity_unused, alu_odd_unused;
    logic           accept, last_iter;

    assign accept = req_valid && req_ready;

`ifdef ALU_SEQ_EARLY_EXIT_EN
    // y is shifted locally, x comes back from the ALU this cycle
    assign last_iter = (iter == LAST_ITER) ||
                       ((cmd == CMD_MUL) ? (y[W-1:1] == '0) : (alu_res == '0));
`else
    assign last_iter = (iter == LAST_ITER);
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        alu_op    = Ops'(ADD);
        alu_a     = '0;
        alu_b     = '0;
        case (state)
            IDLE: if (accept) state_nxt = ADD_PH;
            ADD_PH: begin
                case (cmd)
                    CMD_MUL: begin
                        alu_a = acc;
                        alu_b = x;
                    end
                    CMD_POP: begin
                        alu_a = acc;
                        alu_b = {{(W-1){1'b0}}, x[0]};
                    end
                    CMD_SUBZ: begin
                        alu_op = Ops'(SUB);
                        alu_a  = x;
                        alu_b  = y;
                    end
                    default: ;
                endcase
                state_nxt = (cmd == CMD_MUL || cmd == CMD_POP) ? SHF_PH : DONE;
            end
            SHF_PH: begin
                alu_op    = (cmd == CMD_MUL) ? Ops'(LSH) : Ops'(RSH);
                alu_a     = x;
                alu_b     = W'(1);
                state_nxt = last_iter ? DONE : ADD_PH;
            end
            DONE: if (rsp_valid && rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cmd  <= CMD_SUBZ;
            acc  <= '0;
            x    <= '0;
            y    <= '0;
            iter <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    cmd  <= seq_cmd_t'(req_cmd);
                    acc  <= '0;
                    x    <= req_a;
                    y    <= req_b;
                    iter <= '0;
                end
                // reserved command adds 0+0, so acc stays 0
                ADD_PH: if (cmd != CMD_MUL || y[0]) acc <= alu_res;
                SHF_PH: begin
                    x    <= alu_res;
                    iter <= iter + 1'b1;
                    if (cmd == CMD_MUL) y <= y >> 1;
                end
                default: ;
            endcase
        end
    end

    ALU #(.W(W), .Ops(Ops)) u_alu (
        .OP     (alu_op),
        .InputA (alu_a),
        .InputB (alu_b),
        .SC_in  (1'b0),
        .Result (alu_res),
        .SC_out (alu_sc_unused),
        .Zero   (alu_zero_unused),
        .Parity (alu_parity_unused),
        .Odd    (alu_odd_unused)
    );

    assign req_ready = (state == IDLE) && !Reset;
    assign rsp_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign rsp_data  = acc;
    assign rsp_zero  = ~|acc;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: directed commands checked against a result/latency model of the sequencer
// every cycle, plus hand-computed literal results and latencies.
module tb_alu_seq_ctrl;

    localparam int W   = 8;
    localparam int OPS = 3;
    localparam logic [1:0] C_SUBZ = 2'b00, C_MUL = 2'b01, C_POP = 2'b10, C_RSV = 2'b11;

`ifdef ALU_SEQ_EARLY_EXIT_EN
    localparam int LAT_MUL35 = 6;
    localparam int LAT_POP0  = 2;
    localparam int LAT_MUL0D = 8;
`else
    localparam int LAT_MUL35 = 16;
    localparam int LAT_POP0  = 16;
    localparam int LAT_MUL0D = 16;
`endif

    logic         Clk = 1'b0;
    logic         Reset = 1'b1;
    logic         req_valid = 1'b0;
    logic         rsp_ready = 1'b0;
    logic [1:0]   req_cmd = 2'b00;
    logic [W-1:0] req_a = '0;
    logic [W-1:0] req_b = '0;
    logic         req_ready, rsp_valid, rsp_zero, busy;
    logic [W-1:0] rsp_data;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 Clk = ~Clk;

    alu_seq_ctrl #(.W(W), .Ops(OPS)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_cmd   (req_cmd),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_zero  (rsp_zero),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    // ---------------- model: what the result is and how many edges it takes
    function automatic logic [W-1:0] model_result(input logic [1:0] c, input logic [W-1:0] a,
                                                  input logic [W-1:0] b);
        logic [2*W-1:0] prod;
        prod = '0;
        case (c)
            C_SUBZ:  return a - b;
            C_MUL: begin
                prod = a * b;
                return prod[W-1:0];
            end
            C_POP:   return W'($countones(a));
            default: return '0;
        endcase
    endfunction

    function automatic int model_lat(input logic [1:0] c, input logic [W-1:0] a,
                                     input logic [W-1:0] b);
        int k;
        logic [W-1:0] v;
        if (c == C_MUL || c == C_POP) begin
            v = (c == C_MUL) ? b : a;
            k = 1;
            for (int i = 0; i < W; i++) if (v[i]) k = i + 1;
`ifndef ALU_SEQ_EARLY_EXIT_EN
            k = W;
`endif
            return 2 * k;
        end
        return 1;
    endfunction

    typedef enum int {M_IDLE, M_BUSY, M_DONE} m_phase_t;
    m_phase_t     m_phase  = M_IDLE;
    int           m_left   = 0;
    logic [W-1:0] m_result = '0;
    logic [W-1:0] m_data   = '0;

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            m_phase <= M_IDLE;
            m_left  <= 0;
            m_data  <= '0;
        end else begin
            case (m_phase)
                M_IDLE: if (req_valid) begin
                    m_phase  <= M_BUSY;
                    m_left   <= model_lat(req_cmd, req_a, req_b) - 1;
                    m_result <= model_result(req_cmd, req_a, req_b);
                end
                M_BUSY: if (m_left == 0) begin
                    m_phase <= M_DONE;
                    m_data  <= m_result;
                end else begin
                    m_left <= m_left - 1;
                end
                M_DONE: if (rsp_ready) m_phase <= M_IDLE;
                default: m_phase <= M_IDLE;
            endcase
        end
    end

    always @(negedge Clk) begin
        chk("cyc rsp_valid", rsp_valid, 32'(m_phase == M_DONE));
        chk("cyc busy", busy, 32'(m_phase != M_IDLE));
        chk("cyc req_ready", req_ready, 32'(m_phase == M_IDLE && !Reset));
        if (m_phase != M_BUSY) begin
            chk("cyc rsp_data", rsp_data, 32'(m_data));
            chk("cyc rsp_zero", rsp_zero, 32'(m_data == '0));
        end
    end

    // ---------------- directed stimulus
    task automatic run_cmd(input string name, input logic [1:0] c, input logic [W-1:0] a,
                           input logic [W-1:0] b, input int exp_lat,
                           input logic [W-1:0] exp_data, input int stall);
        int lat = 0;
        chk({name, " ready before"}, req_ready, 1);
        req_cmd   = c;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        @(posedge Clk); #2;
        req_valid = 1'b0;
        while (!rsp_valid && lat < 200) begin
            @(posedge Clk); #2;
            lat++;
        end
        chk({name, " latency"}, lat, exp_lat);
        chk({name, " data"}, rsp_data, 32'(exp_data));
        chk({name, " zero"}, rsp_zero, 32'(exp_data == '0));
        for (int i = 0; i < stall; i++) begin
            if (i == 1) begin
                req_cmd   = C_SUBZ;
                req_a     = 8'h11;
                req_b     = 8'h01;
                req_valid = 1'b1;
            end
            @(posedge Clk); #2;
            req_valid = 1'b0;
            chk({name, " stall data"}, rsp_data, 32'(exp_data));
            chk({name, " stall valid"}, rsp_valid, 1);
            chk({name, " stall ready"}, req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(posedge Clk); #2;
        rsp_ready = 1'b0;
        chk({name, " ready after rsp"}, req_ready, 1);
        chk({name, " valid after rsp"}, rsp_valid, 0);
    endtask

    initial begin
        repeat (3) @(posedge Clk);
        #2;
        chk("reset rsp_valid", rsp_valid, 0);
        chk("reset busy", busy, 0);
        chk("reset req_ready", req_ready, 0);
        chk("reset rsp_data", rsp_data, 0);
        chk("reset rsp_zero", rsp_zero, 1);
        Reset = 1'b0;
        #1;
        chk("ready after release", req_ready, 1);
        @(posedge Clk); #2;

        run_cmd("subz_2a_2a", C_SUBZ, 8'h2A, 8'h2A, 1, 8'h00, 0);
        run_cmd("mul_3x5", C_MUL, 8'd3, 8'd5, LAT_MUL35, 8'd15, 0);
        run_cmd("mul_ffxff", C_MUL, 8'hFF, 8'hFF, 16, 8'h01, 0);
        run_cmd("mul_12x0d", C_MUL, 8'h12, 8'h0D, LAT_MUL0D, 8'hEA, 0);
        run_cmd("pop_b5", C_POP, 8'hB5, 8'h00, 16, 8'd5, 0);
        run_cmd("pop_0", C_POP, 8'h00, 8'h77, LAT_POP0, 8'd0, 0);
        run_cmd("subz_stall", C_SUBZ, 8'h10, 8'h20, 1, 8'hF0, 4);
        run_cmd("rsv", C_RSV, 8'h07, 8'h09, 1, 8'h00, 0);

        // reset five edges into a multiply
        req_cmd   = C_MUL;
        req_a     = 8'd3;
        req_b     = 8'd5;
        req_valid = 1'b1;
        @(posedge Clk); #2;
        req_valid = 1'b0;
        repeat (4) @(posedge Clk);
        #2;
        chk("mid-op busy", busy, 1);
        Reset = 1'b1;
        #1;
        chk("abort busy", busy, 0);
        chk("abort rsp_valid", rsp_valid, 0);
        chk("abort req_ready", req_ready, 0);
        @(posedge Clk); #2;
        Reset = 1'b0;
        @(posedge Clk); #2;
        run_cmd("subz_9_4", C_SUBZ, 8'd9, 8'd4, 1, 8'd5, 0);

        repeat (2) @(posedge Clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule
